// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU: registered single-cycle result/flags on a valid/ready output.
// Define ALU_PIPE_MUL_EN to build the iterative shift-add multiplier (opcode 24).
module alu_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OPC_W  = 6,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opc,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_jump,
  output logic              out_carry,
  output logic              out_illegal
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_STORE = 5'd3;
  localparam logic [4:0] OP_LOAD  = 5'd4;
  localparam logic [4:0] OP_MOVE  = 5'd5;
  localparam logic [4:0] OP_SGE   = 5'd6;
  localparam logic [4:0] OP_SLE   = 5'd7;
  localparam logic [4:0] OP_SGT   = 5'd8;
  localparam logic [4:0] OP_SLT   = 5'd9;
  localparam logic [4:0] OP_SEQ   = 5'd10;
  localparam logic [4:0] OP_SNE   = 5'd11;
  localparam logic [4:0] OP_AND   = 5'd12;
  localparam logic [4:0] OP_OR    = 5'd13;
  localparam logic [4:0] OP_XOR   = 5'd14;
  localparam logic [4:0] OP_NOT   = 5'd15;
  localparam logic [4:0] OP_MOVEI = 5'd16;
  localparam logic [4:0] OP_SLI   = 5'd17;
  localparam logic [4:0] OP_SRI   = 5'd18;
  localparam logic [4:0] OP_ADDI  = 5'd19;
  localparam logic [4:0] OP_SUBI  = 5'd20;
  localparam logic [4:0] OP_JUMP  = 5'd21;
  localparam logic [4:0] OP_BRA   = 5'd22;

  logic [4:0]        w_op;
  logic              w_hi_zero;
  logic [DATA_W:0]   w_add;
  logic [DATA_W:0]   w_sub;
  logic [DATA_W-1:0] w_res;
  logic              w_jump;
  logic              w_carry;
  logic              w_illegal;
  logic              w_is_mul;
  logic              w_idle;
  logic              w_free;
  logic              w_accept;
  logic              w_load_alu;
  logic              w_load_mul;
  logic [DATA_W-1:0] w_mul_res;
  logic [TAG_W-1:0]  w_mul_tag;

  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic [TAG_W-1:0]  r_tag;
  logic              r_jump;
  logic              r_carry;
  logic              r_illegal;

  assign w_op      = in_opc[4:0];
  assign w_hi_zero = ((in_opc >> 5) == '0);
  assign w_add     = {1'b0, in_a} + {1'b0, in_b};
  // Top bit of a + ~b + 1 is the not-borrow flag.
  assign w_sub     = {1'b0, in_a} + {1'b0, ~in_b} + {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    w_res     = '0;
    w_jump    = 1'b0;
    w_carry   = 1'b0;
    w_illegal = 1'b0;
    if (!w_hi_zero) begin
      w_illegal = 1'b1;
    end else begin
      case (w_op)
        OP_NOP:                            w_res = r_result;
        OP_ADD, OP_STORE, OP_LOAD, OP_ADDI: begin
          w_res   = w_add[DATA_W-1:0];
          w_carry = w_add[DATA_W];
        end
        OP_SUB, OP_SUBI: begin
          w_res   = w_sub[DATA_W-1:0];
          w_carry = w_sub[DATA_W];
        end
        OP_MOVE, OP_MOVEI:                 w_res = in_a;
        OP_SGE:   w_res = {{(DATA_W-1){1'b0}}, (in_a >= in_b)};
        OP_SLE:   w_res = {{(DATA_W-1){1'b0}}, (in_a <= in_b)};
        OP_SGT:   w_res = {{(DATA_W-1){1'b0}}, (in_a > in_b)};
        OP_SLT:   w_res = {{(DATA_W-1){1'b0}}, (in_a < in_b)};
        OP_SEQ:   w_res = {{(DATA_W-1){1'b0}}, (in_a == in_b)};
        OP_SNE:   w_res = {{(DATA_W-1){1'b0}}, (in_a != in_b)};
        OP_AND:   w_res = in_a & in_b;
        OP_OR:    w_res = in_a | in_b;
        OP_XOR:   w_res = in_a ^ in_b;
        OP_NOT:   w_res = ~in_a;
        OP_SLI:   w_res = in_a << in_b[SH_W-1:0];
        OP_SRI:   w_res = in_a >> in_b[SH_W-1:0];
        OP_JUMP: begin
          w_res  = in_a;
          w_jump = 1'b1;
        end
        OP_BRA: begin
          w_res  = in_a;
          w_jump = (in_b != '0);
        end
`ifdef ALU_PIPE_MUL_EN
        5'd24:    w_res = '0;  // result comes from the multiplier FSM
`endif
        default:  w_illegal = 1'b1;
      endcase
    end
  end

  assign w_free     = !r_valid || out_ready;
  assign in_ready   = w_idle && w_free;
  assign w_accept   = in_valid && in_ready;
  assign w_load_alu = w_accept && !w_is_mul;

`ifdef ALU_PIPE_MUL_EN
  localparam int unsigned CNT_W   = SH_W + 1;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_MUL  = 2'd1;
  localparam logic [1:0]  ST_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_prod;
  logic [TAG_W-1:0]  r_mtag;

  assign w_is_mul   = w_hi_zero && (w_op == 5'd24);
  assign w_idle     = (r_state == ST_IDLE);
  assign w_load_mul = (r_state == ST_DONE) && w_free;
  assign w_mul_res  = r_prod;
  assign w_mul_tag  = r_mtag;

  // Only the low DATA_W product bits are kept, so the multiplicand shifts out harmlessly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_mtag   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state  <= ST_MUL;
            r_cnt    <= '0;
            r_mcand  <= in_a;
            r_mplier <= in_b;
            r_prod   <= '0;
            r_mtag   <= in_tag;
          end
        end
        ST_MUL: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (w_free) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_idle     = 1'b1;
  assign w_load_mul = 1'b0;
  assign w_mul_res  = '0;
  assign w_mul_tag  = '0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_tag     <= '0;
      r_jump    <= 1'b0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_load_alu) begin
      r_valid   <= 1'b1;
      r_result  <= w_res;
      r_tag     <= in_tag;
      r_jump    <= w_jump;
      r_carry   <= w_carry;
      r_illegal <= w_illegal;
    end else if (w_load_mul) begin
      r_valid   <= 1'b1;
      r_result  <= w_mul_res;
      r_tag     <= w_mul_tag;
      r_jump    <= 1'b0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_result  = r_result;
  assign out_tag     = r_tag;
  assign out_jump    = r_jump;
  assign out_carry   = r_carry;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus randomized traffic against a
// transaction-level reference model.
module tb_alu_pipe;
  localparam int DW = 32;
  localparam int OW = 6;
  localparam int TW = 5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] in_opc = '0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_tag;
  logic          out_jump;
  logic          out_carry;
  logic          out_illegal;

  alu_pipe #(.DATA_W(DW), .OPC_W(OW), .TAG_W(TW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opc     (in_opc),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_jump   (out_jump),
    .out_carry  (out_carry),
    .out_illegal(out_illegal)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic          jmp;
    logic          cy;
    logic          ill;
  } res_t;

  // Model: one output slot plus an optional multiply in flight.
  bit   m_ovalid;
  res_t m_out;
  bit   m_pend;
  int   m_cnt;
  res_t m_pres;

  function automatic bit is_mul(input logic [OW-1:0] opc);
`ifdef ALU_PIPE_MUL_EN
    return (opc == 6'd24);
`else
    return 1'b0;
`endif
  endfunction

  function automatic res_t ref_op(input logic [OW-1:0] opc, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, input logic [TW-1:0] tag,
                                  input logic [DW-1:0] prev);
    res_t r;
    logic [DW:0] s;
    logic [63:0] p;
    r     = '0;
    r.tag = tag;
    case (int'(opc))
      0:             r.res = prev;
      1, 3, 4, 19: begin
        s     = {1'b0, a} + {1'b0, b};
        r.res = s[DW-1:0];
        r.cy  = s[DW];
      end
      2, 20: begin
        r.res = a - b;
        r.cy  = (a >= b);
      end
      5, 16:         r.res = a;
      6:             r.res = (a >= b) ? 32'd1 : 32'd0;
      7:             r.res = (a <= b) ? 32'd1 : 32'd0;
      8:             r.res = (a > b) ? 32'd1 : 32'd0;
      9:             r.res = (a < b) ? 32'd1 : 32'd0;
      10:            r.res = (a == b) ? 32'd1 : 32'd0;
      11:            r.res = (a != b) ? 32'd1 : 32'd0;
      12:            r.res = a & b;
      13:            r.res = a | b;
      14:            r.res = a ^ b;
      15:            r.res = ~a;
      17:            r.res = a << (b % DW);
      18:            r.res = a >> (b % DW);
      21: begin
        r.res = a;
        r.jmp = 1'b1;
      end
      22: begin
        r.res = a;
        r.jmp = (b != 0);
      end
`ifdef ALU_PIPE_MUL_EN
      24: begin
        p     = {32'd0, a} * {32'd0, b};
        r.res = p[DW-1:0];
      end
`endif
      default:       r.ill = 1'b1;
    endcase
    return r;
  endfunction

  // Drive one cycle (called at a negedge), check outputs, advance model, step to next negedge.
  task automatic cycle(input bit v, input logic [OW-1:0] opc, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [TW-1:0] tag, input bit ordy);
    bit   free;
    bit   exp_rdy;
    bit   nv;
    res_t e;
    in_valid  = v;
    in_opc    = opc;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    out_ready = ordy;
    #1;
    free    = !m_ovalid || ordy;
    exp_rdy = !m_pend && free;
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("out_valid", out_valid, m_ovalid);
    if (m_ovalid) begin
      check_eq("out_result", out_result, m_out.res);
      check_eq("out_tag", out_tag, m_out.tag);
      check_eq("out_jump", out_jump, m_out.jmp);
      check_eq("out_carry", out_carry, m_out.cy);
      check_eq("out_illegal", out_illegal, m_out.ill);
    end
    nv = m_ovalid && !ordy;
    if (m_pend) begin
      if (m_cnt == 0) begin
        if (free) begin
          m_out  = m_pres;
          nv     = 1'b1;
          m_pend = 1'b0;
        end
      end else begin
        m_cnt--;
      end
    end
    if (v && exp_rdy) begin
      e = ref_op(opc, a, b, tag, m_out.res);
      if (is_mul(opc)) begin
        m_pend = 1'b1;
        m_cnt  = DW;
        m_pres = e;
      end else begin
        m_out = e;
        nv    = 1'b1;
      end
    end
    m_ovalid = nv;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_result", out_result, 0);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_flags", {out_jump, out_carry, out_illegal}, 0);
    m_ovalid = 1'b0;
    m_out    = '0;
    m_pend   = 1'b0;
    m_cnt    = 0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_eq("rst_in_ready", in_ready, 1);
  endtask

  logic [OW-1:0] op_tab [25] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8,
                                 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16,
                                 6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd24, 6'd23};

  function automatic logic [DW-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'd0;
      2:       return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int k;
    m_ovalid = 1'b0;
    m_out    = '0;
    m_pend   = 1'b0;
    m_cnt    = 0;
    #1;
    check_eq("init_out_valid", out_valid, 0);
    check_eq("init_out_result", out_result, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_eq("init_in_ready", in_ready, 1);
    @(negedge clock);

    cycle(1'b1, 6'd1, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b1);
    check_eq("add_wrap_res", out_result, 0);
    check_eq("add_wrap_carry", out_carry, 1);
    check_eq("add_wrap_tag", out_tag, 3);

    cycle(1'b1, 6'd2, 32'd5, 32'd7, 5'd1, 1'b1);
    check_eq("sub_res", out_result, 32'hFFFF_FFFE);
    check_eq("sub_carry", out_carry, 0);
    cycle(1'b1, 6'd9, 32'd2, 32'd9, 5'd2, 1'b1);
    check_eq("slt_res", out_result, 1);
    cycle(1'b1, 6'd13, 32'hF0, 32'h0F, 5'd4, 1'b1);
    check_eq("or_res", out_result, 32'hFF);

    cycle(1'b1, 6'd14, 32'hAA, 32'h55, 5'd5, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'd1, 32'd7, 32'd8, 5'd6, 1'b0);
    check_eq("stall_hold_res", out_result, 32'hFF);
    check_eq("stall_hold_tag", out_tag, 5);
    cycle(1'b1, 6'd1, 32'd7, 32'd8, 5'd6, 1'b1);
    check_eq("drain_accept_res", out_result, 15);

    cycle(1'b1, 6'd22, 32'd40, 32'd0, 5'd1, 1'b1);
    check_eq("bra_nt_jump", out_jump, 0);
    cycle(1'b1, 6'd22, 32'd40, 32'd1, 5'd1, 1'b1);
    check_eq("bra_t_jump", out_jump, 1);
    cycle(1'b1, 6'd21, 32'd40, 32'd0, 5'd1, 1'b1);
    check_eq("jump_jump", out_jump, 1);
    cycle(1'b1, 6'd31, 32'd40, 32'd3, 5'd2, 1'b1);
    check_eq("illegal_res", out_result, 0);
    check_eq("illegal_flag", out_illegal, 1);

    cycle(1'b1, 6'd1, 32'd2, 32'd3, 5'd1, 1'b1);
    cycle(1'b1, 6'd0, 32'd9, 32'd9, 5'd7, 1'b1);
    check_eq("nop_res", out_result, 5);
    check_eq("nop_tag", out_tag, 7);
    cycle(1'b1, 6'd0, 32'd1, 32'd1, 5'd8, 1'b1);
    check_eq("nop2_res", out_result, 5);
    cycle(1'b1, 6'd17, 32'd1, 32'd37, 5'd1, 1'b1);
    check_eq("sli_mask_res", out_result, 32'h20);

`ifdef ALU_PIPE_MUL_EN
    cycle(1'b1, 6'd24, 32'd1234, 32'd5678, 5'd9, 1'b1);
    k = 0;
    while (!out_valid && k < 100) begin
      cycle(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1);
      k++;
    end
    check_eq("mul_latency", k, DW + 1);
    check_eq("mul_res", out_result, 32'd7006652);
    check_eq("mul_tag", out_tag, 9);
    cycle(1'b1, 6'd24, 32'h1234_5678, 32'h9ABC_DEF1, 5'd2, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1);
    do_reset();
`else
    cycle(1'b1, 6'd24, 32'd1234, 32'd5678, 5'd9, 1'b1);
    check_eq("mul_off_res", out_result, 0);
    check_eq("mul_off_illegal", out_illegal, 1);
    cycle(1'b1, 6'd1, 32'd3, 32'd4, 5'd2, 1'b0);
    do_reset();
`endif
    cycle(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      logic [OW-1:0] opc;
      if ($urandom_range(0, 9) == 0) opc = OW'($urandom_range(0, 63));
      else opc = op_tab[$urandom_range(0, 24)];
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, opc, rand_operand(), rand_operand(),
            TW'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 40; i++) cycle(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
